// File: rtl/jtag_link_responder.sv
// jtag_link_responder: sends a 12-bit pulse code as two bytes, then collects
// NUM_SAMPLES 10-bit samples (each sent as a low/high byte pair), acknowledges
// each one, strobes it out and stores it in a readable sample buffer.
module jtag_link_responder #(
    parameter int unsigned NUM_SAMPLES = 32,
    parameter logic [7:0]  ACK_BYTE    = 8'h80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [11:0] pulse_value,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        sample_valid,
    output logic [9:0]  sample_data,
    output logic [4:0]  sample_index,
    input  logic [4:0]  rd_addr,
    output logic [9:0]  rd_data
);

    localparam int unsigned IDX_W    = 5;
    localparam int unsigned SAMPLE_W = 10;
    localparam int unsigned BYTE_W   = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TX_LO  = 3'd1,
        TX_HI  = 3'd2,
        RX_LO  = 3'd3,
        RX_HI  = 3'd4,
        TX_ACK = 3'd5,
        DONE   = 3'd6
    } state_e;

    state_e              state_q;
    logic [11:0]         pulse_q;
    logic [4:0]          low_q;
    logic [IDX_W-1:0]    idx_q;
    logic                tx_valid_q;
    logic [BYTE_W-1:0]   tx_data_q;
    logic                rx_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                sample_valid_q;
    logic [SAMPLE_W-1:0] sample_data_q;
    logic [IDX_W-1:0]    sample_index_q;
    logic [SAMPLE_W-1:0] rd_data_q;
    logic [SAMPLE_W-1:0] mem_q [NUM_SAMPLES];

    logic [SAMPLE_W-1:0] sample_d;
    logic                wr_en_d;

    // Assembled sample and buffer write strobe for the completing high byte.
    always_comb begin
        sample_d = {rx_data[4:0], low_q};
        wr_en_d  = (state_q == RX_HI) && rx_valid && (rx_data[7:5] == 3'b111);
    end

    // Transaction FSM; every output register is updated with the state it enters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            pulse_q        <= '0;
            low_q          <= '0;
            idx_q          <= '0;
            tx_valid_q     <= 1'b0;
            tx_data_q      <= '0;
            rx_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
            sample_index_q <= '0;
        end else begin
            done_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pulse_q    <= pulse_value;
                        err_q      <= 1'b0;
                        idx_q      <= '0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= {2'b00, pulse_value[5:0]};
                        busy_q     <= 1'b1;
                        state_q    <= TX_LO;
                    end
                end
                TX_LO: begin
                    if (tx_ready) begin
                        tx_data_q <= {2'b11, pulse_q[11:6]};
                        state_q   <= TX_HI;
                    end
                end
                TX_HI: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= '0;
                        rx_ready_q <= 1'b1;
                        state_q    <= RX_LO;
                    end
                end
                RX_LO: begin
                    if (rx_valid) begin
                        if (rx_data[7:5] == 3'b000) begin
                            low_q   <= rx_data[4:0];
                            state_q <= RX_HI;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RX_HI: begin
                    if (rx_valid) begin
                        case (rx_data[7:5])
                            3'b111: begin
                                sample_valid_q <= 1'b1;
                                sample_data_q  <= sample_d;
                                sample_index_q <= idx_q;
                                rx_ready_q     <= 1'b0;
                                tx_valid_q     <= 1'b1;
                                tx_data_q      <= ACK_BYTE;
                                state_q        <= TX_ACK;
                            end
                            3'b000: begin
                                low_q <= rx_data[4:0];
                                err_q <= 1'b1;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                TX_ACK: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= '0;
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q      <= idx_q + IDX_W'(1);
                            rx_ready_q <= 1'b1;
                            state_q    <= RX_LO;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Sample buffer storage; deliberately not reset so contents survive an abort.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem_q[idx_q] <= sample_d;
        end
    end

    // Registered read port; a same-edge write is seen on the following read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (32'(rd_addr) < NUM_SAMPLES) begin
            rd_data_q <= mem_q[rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign tx_valid     = tx_valid_q;
    assign tx_data      = tx_data_q;
    assign rx_ready     = rx_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign sample_valid = sample_valid_q;
    assign sample_data  = sample_data_q;
    assign sample_index = sample_index_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_jtag_link_responder.sv
// Directed bench for jtag_link_responder: pulse bytes, full 32-sample run,
// back-pressure, rx protocol errors, ignored start, and mid-transaction reset.
module tb_jtag_link_responder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [11:0] pulse_value;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic        sample_valid;
    logic [9:0]  sample_data;
    logic [4:0]  sample_index;
    logic [4:0]  rd_addr;
    logic [9:0]  rd_data;

    int n_cmp = 0;
    int n_bad = 0;
    int sv_cnt = 0;
    int ack_cnt = 0;
    int done_cnt = 0;

    jtag_link_responder #(.NUM_SAMPLES(32), .ACK_BYTE(8'h80)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .pulse_value  (pulse_value),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_index (sample_index),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters for strobes and ACK transfers.
    always @(posedge clk) begin
        if (sample_valid) sv_cnt++;
        if (done) done_cnt++;
        if (tx_valid && tx_ready && tx_data == 8'h80) ack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a tx byte, check it, and accept it for one cycle.
    task automatic expect_tx(input string tag, input logic [7:0] exp);
        int n = 0;
        while (tx_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " tx_valid"}, 32'(tx_valid), 32'd1);
        check({tag, " tx_data"}, 32'(tx_data), 32'(exp));
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    // Offer one rx byte and hold it until (bounded) it is accepted.
    task automatic send_rx(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rx accept", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, " tx_data"}, 32'(tx_data), 32'd0);
        check({tag, " rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
        check({tag, " sample_valid"}, 32'(sample_valid), 32'd0);
        check({tag, " sample_data"}, 32'(sample_data), 32'd0);
        check({tag, " sample_index"}, 32'(sample_index), 32'd0);
        check({tag, " rd_data"}, 32'(rd_data), 32'd0);
    endtask

    initial begin
        int sv0;
        int ack0;
        reset_n     = 1'b0;
        start       = 1'b0;
        pulse_value = 12'h000;
        tx_ready    = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        rd_addr     = 5'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Release reset and start on the very next edge.
        reset_n     = 1'b1;
        start       = 1'b1;
        pulse_value = 12'hA5C;
        @(negedge clk);
        start = 1'b0;
        check("lo busy", 32'(busy), 32'd1);
        check("lo rx_ready", 32'(rx_ready), 32'd0);
        check("lo tx_valid", 32'(tx_valid), 32'd1);
        check("lo tx_data", 32'(tx_data), 32'h1C);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;

        // Back-pressure in TX_HI: byte and valid hold for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            check("hold tx_data", 32'(tx_data), 32'hE9);
            check("hold tx_valid", 32'(tx_valid), 32'd1);
            check("hold rx_ready", 32'(rx_ready), 32'd0);
            @(negedge clk);
        end
        expect_tx("hi", 8'hE9);
        check("rxlo rx_ready", 32'(rx_ready), 32'd1);
        check("rxlo tx_valid", 32'(tx_valid), 32'd0);
        check("rxlo busy", 32'(busy), 32'd1);

        // Full 32-sample run with 0x03/0xE1 per sample.
        sv0  = sv_cnt;
        ack0 = ack_cnt;
        for (int s = 0; s < 32; s++) begin
            send_rx(8'h03);
            send_rx(8'hE1);
            check("run sample_valid", 32'(sample_valid), 32'd1);
            check("run sample_data", 32'(sample_data), 32'h023);
            check("run sample_index", 32'(sample_index), 32'(s));
            if (s == 0) begin
                // start and rx_valid while waiting on the ACK must be ignored.
                start    = 1'b1;
                rx_valid = 1'b1;
                rx_data  = 8'h03;
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    check("ack rx_ready", 32'(rx_ready), 32'd0);
                    check("ack tx_data", 32'(tx_data), 32'h80);
                    check("ack busy", 32'(busy), 32'd1);
                end
                start    = 1'b0;
                rx_valid = 1'b0;
                rx_data  = 8'h00;
            end
            expect_tx("ack", 8'h80);
        end
        check("done pulse", 32'(done), 32'd1);
        check("done busy", 32'(busy), 32'd1);
        check("done tx_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("after done", 32'(done), 32'd0);
        check("idle busy", 32'(busy), 32'd0);
        check("run err", 32'(err), 32'd0);
        check("sample count", 32'(sv_cnt - sv0), 32'd32);
        check("ack count", 32'(ack_cnt - ack0), 32'd32);
        rd_addr = 5'd0;
        @(negedge clk);
        check("buf[0]", 32'(rd_data), 32'h023);
        rd_addr = 5'd17;
        @(negedge clk);
        check("buf[17]", 32'(rd_data), 32'h023);
        rd_addr = 5'd31;
        @(negedge clk);
        check("buf[31]", 32'(rd_data), 32'h023);

        // rx protocol errors on the first sample of a new transaction.
        start       = 1'b1;
        pulse_value = 12'h000;
        @(negedge clk);
        start = 1'b0;
        expect_tx("p0 lo", 8'h00);
        expect_tx("p0 hi", 8'hC0);
        send_rx(8'hE1);
        check("bad lo err", 32'(err), 32'd1);
        check("bad lo stays", 32'(rx_ready), 32'd1);
        check("bad lo no sample", 32'(sample_valid), 32'd0);
        send_rx(8'h03);
        send_rx(8'h05);
        send_rx(8'h40);
        check("bad hi no sample", 32'(sample_valid), 32'd0);
        rd_addr = 5'd0;
        send_rx(8'hE2);
        check("err sample_valid", 32'(sample_valid), 32'd1);
        check("err sample_data", 32'(sample_data), 32'h045);
        check("err sample_index", 32'(sample_index), 32'd0);
        check("old read", 32'(rd_data), 32'h023);
        @(negedge clk);
        check("new read", 32'(rd_data), 32'h045);
        check("err sticky", 32'(err), 32'd1);
        expect_tx("ack0", 8'h80);
        for (int s = 1; s < 7; s++) begin
            send_rx(8'h03);
            send_rx(8'hE1);
            expect_tx("ack", 8'h80);
        end
        send_rx(8'h03);
        rd_addr = 5'd31;
        @(negedge clk);
        check("pre-reset rd", 32'(rd_data), 32'h023);
        check("pre-reset idx", 32'(sample_index), 32'd6);

        // Asynchronous reset in RX_HI of sample 7.
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort no done", 32'(done_cnt), 32'd1);
        reset_n     = 1'b1;
        start       = 1'b1;
        pulse_value = 12'h0C3;
        @(negedge clk);
        start = 1'b0;
        check("restart busy", 32'(busy), 32'd1);
        expect_tx("re lo", 8'h03);
        expect_tx("re hi", 8'hC3);
        send_rx(8'h03);
        send_rx(8'hE1);
        check("re sample_valid", 32'(sample_valid), 32'd1);
        check("re sample_index", 32'(sample_index), 32'd0);
        check("re sample_data", 32'(sample_data), 32'h023);
        check("re err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jtag_link_responder.md
JTAG_LINK_RESPONDER -- requirements
Module: jtag_link_responder

Interface
REQ-001 SHALL have parameter NUM_SAMPLES, default 32, meaning the number of 10-bit samples per transaction (range 2..32).
REQ-002 SHALL have parameter ACK_BYTE, default 8'h80, meaning the acknowledge byte; bits [7:6] SHALL be 2'b10.
REQ-003 SHALL provide clk  in  1  system clock; all logic is on the rising edge.
REQ-004 SHALL provide reset_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL provide start  in  1  single-cycle request to begin a transaction.
REQ-006 SHALL provide pulse_value  in  12  DAC pulse code, sampled when start is accepted.
REQ-007 SHALL provide tx_valid  out  1, tx_data  out  8, tx_ready  in  1  as the byte stream toward the device.
REQ-008 SHALL provide rx_valid  in  1, rx_data  in  8, rx_ready  out  1  as the byte stream from the device.
REQ-009 SHALL provide busy  out  1  high while a transaction is in progress.
REQ-010 SHALL provide done  out  1  one-cycle pulse when a transaction completes.
REQ-011 SHALL provide err  out  1  sticky protocol-error flag.
REQ-012 SHALL provide sample_valid  out  1, sample_data  out  10, sample_index  out  5  as the decoded-sample strobe.
REQ-013 SHALL provide rd_addr  in  5, rd_data  out  10  as the sample-buffer read port with 1-cycle registered latency.

Function
REQ-014 SHALL transfer a byte on any cycle where valid and ready are both high; tx_data SHALL be held stable while tx_valid=1 and tx_ready=0.
REQ-015 SHALL implement states IDLE, TX_LO, TX_HI, RX_LO, RX_HI, TX_ACK, DONE.
REQ-016 In IDLE, start=1 SHALL latch pulse_value, clear err and the sample index, and move to TX_LO; start SHALL be ignored in every other state.
REQ-017 In TX_LO, tx_valid SHALL be 1 and tx_data SHALL be {2'b00, pulse_value[5:0]}; on transfer the block SHALL go to TX_HI.
REQ-018 In TX_HI, tx_data SHALL be {2'b11, pulse_value[11:6]}; on transfer the block SHALL go to RX_LO.
REQ-019 rx_ready SHALL be 1 only in RX_LO and RX_HI.
REQ-020 In RX_LO, a byte with [7:5]=3'b000 SHALL have [4:0] held as the low half, and the block SHALL go to RX_HI.
REQ-021 In RX_LO, any other byte SHALL be discarded, set err, and leave the state unchanged.
REQ-022 In RX_HI, a byte with [7:5]=3'b111 SHALL complete the sample {rx_data[4:0], low[4:0]}.
REQ-023 In RX_HI, a byte with [7:5]=3'b000 SHALL replace the held low half, set err, and stay in RX_HI.
REQ-024 In RX_HI, any other byte pattern SHALL be discarded and set err.
REQ-025 On sample completion, the block SHALL write the buffer at the current index and go to TX_ACK.
REQ-026 On the following cycle, sample_valid SHALL be 1 for exactly one cycle with sample_data and sample_index valid.
REQ-027 In TX_ACK, tx_data SHALL be ACK_BYTE.
REQ-028 On ACK transfer, if index = NUM_SAMPLES-1 the block SHALL go to DONE; otherwise it SHALL increment the index and go to RX_LO.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE; buffer contents SHALL be retained until overwritten.
REQ-030 busy SHALL be 1 in every state except IDLE, including DONE.
REQ-031 tx_valid SHALL be 1 only in TX_LO, TX_HI and TX_ACK.
REQ-032 rd_data SHALL equal buffer[rd_addr] one cycle after rd_addr is presented; a same-cycle write to the addressed entry SHALL return the old data.
REQ-033 The sample index SHALL never wrap; indices at or above NUM_SAMPLES SHALL never be written.

Reset
REQ-034 While reset_n=0: state=IDLE and tx_valid, tx_data, rx_ready, busy, done, err, sample_valid, sample_data, sample_index, rd_data SHALL all be 0.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction immediately without a done pulse; buffer contents SHALL be left undefined-but-unchanged.
REQ-036 After reset_n deasserts, the first start SHALL be honoured on the first clock edge.

Verification
REQ-037 Scenario: pulse_value=12'hA5C, start, tx_ready=1 -> tx bytes 8'h1C then 8'hE9, busy=1, rx_ready=1 in RX_LO.
REQ-038 Scenario: full NUM_SAMPLES=32 run, device sends 0x03,0xE1 per sample -> 32 sample_valid pulses of 10'h023 with indices 0..31, 32 ACK bytes 8'h80, done one cycle after the last ACK, buffer reads 10'h023.
REQ-039 Scenario: tx_ready held 0 for 10 cycles during TX_HI -> tx_data stays 8'hE9 and tx_valid stays 1; no state advance.
REQ-040 Scenario: in RX_LO send 0xE1, then 0x03, 0x05, 0xE2 -> err=1, the first 0xE1 is discarded, and the sample completes as 10'h045.
REQ-041 Scenario: reset_n pulsed low during RX_HI of sample 7 -> all outputs 0 and state IDLE; a new start re-sends the pulse bytes and the index restarts at 0.
REQ-042 Scenario: start asserted while busy, and rx_valid asserted during TX_ACK -> start is ignored, rx_ready=0, and no extra sample is produced.
